// File: rtl/gate_response_checker.sv
//------------------------------------------------------------------------------
// gate_response_checker: samples AND/OR/NOT gate outputs after a settle delay,
// checks them against the truth table and keeps pass/fail statistics.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gate_response_checker #(
   parameter int SETTLE_CYCLES = 4,
   parameter int NUM_VECTORS   = 6,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vec_valid,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             t0,
   input  logic             t1,
   input  logic             t2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [5:0]       first_fail_vec,
   output logic             err_sticky
);

   localparam int               SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_VECTORS);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state_q;
   logic [2:0]       vec_q;
   logic [SW-1:0]    settle_q;
   logic [CNT_W-1:0] idx_q;
   logic [CNT_W-1:0] match_q;
   logic [CNT_W-1:0] mismatch_q;
   logic [CNT_W-1:0] ffi_q;
   logic [5:0]       ffv_q;
   logic             err_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;

   logic [2:0]       exp_d;
   logic [2:0]       obs_d;
   logic             hit_d;
   logic [CNT_W-1:0] match_d;
   logic [CNT_W-1:0] mismatch_d;
   logic [CNT_W-1:0] idx_d;
   logic             last_d;

   // Expected response comes only from the latched vector, never the live pins.
   always_comb begin
      exp_d      = {vec_q[2] & vec_q[1], vec_q[2] | vec_q[1], ~vec_q[0]};
      obs_d      = {t0, t1, t2};
      hit_d      = (exp_d == obs_d);
      match_d    = (match_q == CNT_MAX) ? match_q : match_q + CNT_W'(1);
      mismatch_d = (mismatch_q == CNT_MAX) ? mismatch_q : mismatch_q + CNT_W'(1);
      idx_d      = idx_q + CNT_W'(1);
      last_d     = (idx_d == LAST_IDX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         settle_q   <= '0;
         idx_q      <= '0;
         match_q    <= '0;
         mismatch_q <= '0;
         ffi_q      <= '0;
         ffv_q      <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q    <= S_ARM;
                  idx_q      <= '0;
                  match_q    <= '0;
                  mismatch_q <= '0;
                  ffi_q      <= '0;
                  ffv_q      <= '0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
               end
            end
            S_ARM: begin
               if (vec_valid) begin
                  vec_q <= {a, b, c};
                  if (SETTLE_CYCLES == 0) begin
                     state_q <= S_SAMPLE;
                  end else begin
                     state_q  <= S_SETTLE;
                     settle_q <= SETTLE_LOAD;
                  end
               end
            end
            S_SETTLE: begin
               if (settle_q <= SW'(1)) begin
                  state_q <= S_SAMPLE;
               end else begin
                  settle_q <= settle_q - SW'(1);
               end
            end
            S_SAMPLE: begin
               if (hit_d) begin
                  match_q <= match_d;
               end else begin
                  mismatch_q <= mismatch_d;
                  if (!err_q) begin
                     ffi_q <= idx_q;
                     ffv_q <= {vec_q, obs_d};
                     err_q <= 1'b1;
                  end
               end
               idx_q <= idx_d;
               if (last_d) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= hit_d && (mismatch_q == '0) && !err_q;
               end else begin
                  state_q <= S_ARM;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign match_cnt      = match_q;
   assign mismatch_cnt   = mismatch_q;
   assign first_fail_idx = ffi_q;
   assign first_fail_vec = ffv_q;
   assign err_sticky     = err_q;

endmodule

`default_nettype wire
